// File: rtl/arm_wait_mem.sv
// Memory slave for the arm7tdmi mem_* bus with independent read/write wait states,
// out-of-range error responses and saturating access counters.
module arm_wait_mem #(
   parameter int unsigned DEPTH_WORDS = 2048,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned READ_WAIT   = 0,
   parameter int unsigned WRITE_WAIT  = 0,
   parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF,
   parameter string       INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_be,
   input  logic        mem_we,
   input  logic        mem_re,
   output logic [31:0] mem_rdata,
   output logic        mem_ready,
   output logic        mem_err,
   output logic [31:0] stat_rd_cnt,
   output logic [31:0] stat_wr_cnt,
   output logic        busy
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [3:0] RW4 = 4'(READ_WAIT);
   localparam logic [3:0] WW4 = 4'(WRITE_WAIT);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   logic [31:0] mem_q [DEPTH_WORDS];

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        be_q, be_d;
   logic              we_q, we_d, re_q, re_d, inr_q, inr_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [31:0]       rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

   logic [31:0]       off;
   logic              in_rng, req;
   logic [IDX_W-1:0]  idx;
   logic [3:0]        n_wait;
   logic              wr_en, rd_inc, wr_inc;
   logic [IDX_W-1:0]  wr_idx;
   logic [31:0]       wr_data;
   logic [3:0]        wr_be;
   logic              unused_bits;

   // BASE_ADDR is aligned to the span, so range check reduces to the high offset bits being zero
   assign off         = mem_addr - BASE_ADDR;
   assign in_rng      = (off[31:IDX_W+2] == '0);
   assign idx         = off[IDX_W+1:2];
   assign req         = mem_we | mem_re;
   assign n_wait      = mem_we ? WW4 : RW4;
   assign unused_bits = ^{off[1:0], INIT_FILE.len()};

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      we_d      = we_q;
      re_d      = re_q;
      inr_d     = inr_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      mem_ready = 1'b1;
      mem_rdata = rdata_q;
      mem_err   = err_q;
      wr_en     = 1'b0;
      wr_idx    = idx;
      wr_data   = mem_wdata;
      wr_be     = mem_be;
      rd_inc    = 1'b0;
      wr_inc    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               if (n_wait == 4'd0) begin
                  mem_err = ~in_rng | (mem_we & mem_re);
                  if (mem_we) begin
                     wr_en  = in_rng;
                     wr_inc = 1'b1;
                  end else begin
                     mem_rdata = in_rng ? mem_q[idx] : ERR_DATA;
                     rd_inc    = 1'b1;
                  end
               end else begin
                  mem_ready = 1'b0;
                  idx_d     = idx;
                  wdata_d   = mem_wdata;
                  be_d      = mem_be;
                  we_d      = mem_we;
                  re_d      = mem_re;
                  inr_d     = in_rng;
                  cnt_d     = n_wait - 4'd1;
                  state_d   = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            mem_ready = 1'b0;
            if (cnt_q == 4'd0) begin
               wr_en   = we_q & inr_q;
               wr_idx  = idx_q;
               wr_data = wdata_q;
               wr_be   = be_q;
               if (!we_q) rdata_d = inr_q ? mem_q[idx_q] : ERR_DATA;
               err_d   = ~inr_q | (we_q & re_q);
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            wr_inc  = we_q;
            rd_inc  = ~we_q;
            err_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      rd_cnt_d = (rd_inc && rd_cnt_q != '1) ? rd_cnt_q + 32'd1 : rd_cnt_q;
      wr_cnt_d = (wr_inc && wr_cnt_q != '1) ? wr_cnt_q + 32'd1 : wr_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         we_q     <= 1'b0;
         re_q     <= 1'b0;
         inr_q    <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         we_q     <= we_d;
         re_q     <= re_d;
         inr_q    <= inr_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   // Array is deliberately not reset; a reset during WAIT drops wr_en before the commit edge
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++)
            if (wr_be[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
   end

   assign stat_rd_cnt = rd_cnt_q;
   assign stat_wr_cnt = wr_cnt_q;
   assign busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_arm_wait_mem.sv
// Three differently configured instances driven with directed and random traffic,
// checked every cycle against a transaction-level model of the bus contract.
module tb_arm_wait_mem;
   localparam logic [2:0][31:0] DEP  = {32'd4096, 32'd2048, 32'd2048};
   localparam logic [2:0][31:0] BASE = {32'h0000_0000, 32'h8000_0000, 32'h0000_0000};
   localparam logic [2:0][3:0]  RWP  = {4'd1, 4'd3, 4'd0};
   localparam logic [2:0][3:0]  WWP  = {4'd4, 4'd2, 4'd0};
   localparam logic [31:0]      ERRD = 32'hDEAD_BEEF;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [2:0][31:0] addr_s, wdata_s, rdata_s, rd_cnt_s, wr_cnt_s;
   logic [2:0][3:0]  be_s;
   logic [2:0]       we_s, re_s, ready_s, err_s, busy_s;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      arm_wait_mem #(
         .DEPTH_WORDS(DEP[g]), .BASE_ADDR(BASE[g]),
         .READ_WAIT(RWP[g]), .WRITE_WAIT(WWP[g]),
         .ERR_DATA(ERRD), .INIT_FILE("")
      ) u_dut (
         .clk(clk), .rst_n(rst_n),
         .mem_addr(addr_s[g]), .mem_wdata(wdata_s[g]), .mem_be(be_s[g]),
         .mem_we(we_s[g]), .mem_re(re_s[g]),
         .mem_rdata(rdata_s[g]), .mem_ready(ready_s[g]), .mem_err(err_s[g]),
         .stat_rd_cnt(rd_cnt_s[g]), .stat_wr_cnt(wr_cnt_s[g]), .busy(busy_s[g])
      );
   end

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] mmem [int];
   int          phase [3];
   logic        t_we [3], t_re [3], t_err [3];
   logic [31:0] t_addr [3], t_wdata [3];
   logic [3:0]  t_be [3];
   logic [31:0] held [3];
   bit          held_ok [3];
   logic [31:0] mrd [3], mwr [3];
   logic [31:0] ev;
   bit          eok;
   int          nw;

   function automatic bit inr(input int i, input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE[i];
      return off < DEP[i] * 4;
   endfunction

   function automatic int key(input int i, input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE[i];
      return i * 100000 + int'(off >> 2);
   endfunction

   task automatic mwrite(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] w;
      int k;
      if (!inr(i, a)) return;
      k = key(i, a);
      if (be == 4'hF) mmem[k] = d;
      else if (mmem.exists(k)) begin
         w = mmem[k];
         for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
         mmem[k] = w;
      end
   endtask

   task automatic mread(input int i, input logic [31:0] a, output logic [31:0] v, output bit ok);
      int k;
      k = key(i, a);
      if (!inr(i, a)) begin v = ERRD; ok = 1'b1; end
      else if (mmem.exists(k)) begin v = mmem[k]; ok = 1'b1; end
      else begin v = '0; ok = 1'b0; end
   endtask

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            chk("rst_busy", 32'(busy_s[i]), 32'd0);
            chk("rst_rdata", rdata_s[i], 32'd0);
            chk("rst_rd_cnt", rd_cnt_s[i], 32'd0);
            chk("rst_wr_cnt", wr_cnt_s[i], 32'd0);
            if (!we_s[i] && !re_s[i]) begin
               chk("rst_ready", 32'(ready_s[i]), 32'd1);
               chk("rst_err", 32'(err_s[i]), 32'd0);
            end
            phase[i] = 0; held[i] = '0; held_ok[i] = 1'b1; mrd[i] = '0; mwr[i] = '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            chk("rd_cnt", rd_cnt_s[i], mrd[i]);
            chk("wr_cnt", wr_cnt_s[i], mwr[i]);
            if (phase[i] == 0) begin
               if (!(we_s[i] || re_s[i])) begin
                  chk("idle_ready", 32'(ready_s[i]), 32'd1);
                  chk("idle_busy", 32'(busy_s[i]), 32'd0);
                  chk("idle_err", 32'(err_s[i]), 32'd0);
                  if (held_ok[i]) chk("idle_rdata", rdata_s[i], held[i]);
               end else begin
                  nw = we_s[i] ? int'(WWP[i]) : int'(RWP[i]);
                  if (nw == 0) begin
                     chk("zw_ready", 32'(ready_s[i]), 32'd1);
                     chk("zw_busy", 32'(busy_s[i]), 32'd0);
                     chk("zw_err", 32'(err_s[i]), 32'(!inr(i, addr_s[i]) || (we_s[i] && re_s[i])));
                     if (we_s[i]) begin
                        mwrite(i, addr_s[i], wdata_s[i], be_s[i]);
                        mwr[i] = sat_inc(mwr[i]);
                     end else begin
                        mread(i, addr_s[i], ev, eok);
                        if (eok) chk("zw_rdata", rdata_s[i], ev);
                        mrd[i] = sat_inc(mrd[i]);
                     end
                  end else begin
                     chk("acc_ready", 32'(ready_s[i]), 32'd0);
                     chk("acc_busy", 32'(busy_s[i]), 32'd0);
                     t_we[i] = we_s[i]; t_re[i] = re_s[i]; t_addr[i] = addr_s[i];
                     t_wdata[i] = wdata_s[i]; t_be[i] = be_s[i];
                     phase[i] = nw + 1;
                  end
               end
            end else if (phase[i] >= 2) begin
               chk("wait_ready", 32'(ready_s[i]), 32'd0);
               chk("wait_busy", 32'(busy_s[i]), 32'd1);
               chk("wait_err", 32'(err_s[i]), 32'd0);
               if (held_ok[i]) chk("wait_rdata", rdata_s[i], held[i]);
               if (phase[i] == 2) begin
                  t_err[i] = !inr(i, t_addr[i]) || (t_we[i] && t_re[i]);
                  if (t_we[i]) mwrite(i, t_addr[i], t_wdata[i], t_be[i]);
                  else begin
                     mread(i, t_addr[i], ev, eok);
                     held[i] = ev; held_ok[i] = eok;
                  end
               end
               phase[i]--;
            end else begin
               chk("resp_ready", 32'(ready_s[i]), 32'd1);
               chk("resp_busy", 32'(busy_s[i]), 32'd1);
               chk("resp_err", 32'(err_s[i]), 32'(t_err[i]));
               if (held_ok[i]) chk("resp_rdata", rdata_s[i], held[i]);
               if (t_we[i]) mwr[i] = sat_inc(mwr[i]);
               else mrd[i] = sat_inc(mrd[i]);
               phase[i] = 0;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic access(input int i, input bit we, input bit re, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be, input int linger,
                         output logic [31:0] rd, output bit er, output int cyc);
      @(posedge clk); #1;
      we_s[i] = we; re_s[i] = re; addr_s[i] = a; wdata_s[i] = d; be_s[i] = be;
      cyc = 0; rd = '0; er = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (ready_s[i]) begin cyc = k; rd = rdata_s[i]; er = err_s[i]; break; end
      end
      if (cyc == 0) begin
         total++; bad++;
         $display("FAIL timeout inst %0d: no ready within 40 cycles", i);
      end
      repeat (linger) @(posedge clk);
      @(posedge clk); #1;
      we_s[i] = 1'b0; re_s[i] = 1'b0;
   endtask

   task automatic rnd_run(input int i, input int n_ops);
      logic [31:0] off, a, rd;
      bit er;
      int cyc, sel, k, kind;
      for (int t = 0; t < n_ops; t++) begin
         sel = $urandom_range(0, 15);
         k = $urandom_range(0, 7);
         if (sel < 11) off = 32'h1000 + 32'(4 * k);
         else if (sel < 14) off = DEP[i] * 4 + 32'h1000 + 32'(4 * k);
         else off = 32'hFFFF_FFF0;
         a = BASE[i] + off + 32'($urandom_range(0, 3));
         kind = $urandom_range(0, 9);
         access(i, (kind < 4) || (kind == 9), kind >= 4, a, 32'($urandom), 4'($urandom),
                ($urandom_range(0, 4) == 0) ? 1 : 0, rd, er, cyc);
      end
   endtask

   logic [31:0] rd;
   bit er;
   int cyc;

   initial begin
      we_s = '0; re_s = '0; addr_s = '0; wdata_s = '0; be_s = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("por_ready1", 32'(ready_s[1]), 32'd1);
      chk("por_rdata2", rdata_s[2], 32'd0);
      @(posedge clk); #3 rst_n = 1'b1;

      // zero-wait write then read
      access(0, 1, 0, 32'h1000, 32'h1234_5678, 4'hF, 0, rd, er, cyc);
      chk("zw_wr_cyc", cyc, 1);
      access(0, 0, 1, 32'h1000, 32'h0, 4'h0, 0, rd, er, cyc);
      chk("zw_rd_cyc", cyc, 1);
      chk("zw_rd_data", rd, 32'h1234_5678);
      @(negedge clk);
      chk("zw_wr_cnt", wr_cnt_s[0], 32'd1);
      chk("zw_rd_cnt", rd_cnt_s[0], 32'd1);

      // byte lanes
      access(0, 1, 0, 32'h1010, 32'h1111_1111, 4'hF, 0, rd, er, cyc);
      access(0, 1, 0, 32'h1010, 32'hAABB_CCDD, 4'b0101, 0, rd, er, cyc);
      access(0, 0, 1, 32'h1010, 32'h0, 4'h0, 0, rd, er, cyc);
      chk("be_data", rd, 32'h11BB_11DD);

      // out of range read and aliasing write
      access(0, 1, 0, 32'h0000, 32'h00C0_FFEE, 4'hF, 0, rd, er, cyc);
      access(0, 0, 1, 32'h2000, 32'h0, 4'h0, 0, rd, er, cyc);
      chk("oor_rd_data", rd, 32'hDEAD_BEEF);
      chk("oor_rd_err", 32'(er), 32'd1);
      access(0, 1, 0, 32'h2000, 32'h9999_9999, 4'hF, 0, rd, er, cyc);
      chk("oor_wr_err", 32'(er), 32'd1);
      access(0, 0, 1, 32'h0000, 32'h0, 4'h0, 0, rd, er, cyc);
      chk("alias_data", rd, 32'h00C0_FFEE);
      chk("alias_err", 32'(er), 32'd0);

      // registered read with READ_WAIT=3
      access(1, 1, 0, 32'h8000_1004, 32'hABCD_EF00, 4'hF, 0, rd, er, cyc);
      chk("ww2_cyc", cyc, 4);
      access(1, 0, 1, 32'h8000_1004, 32'h0, 4'h0, 0, rd, er, cyc);
      chk("rw3_cyc", cyc, 5);
      chk("rw3_data", rd, 32'hABCD_EF00);
      repeat (2) @(negedge clk);
      chk("rw3_hold", rdata_s[1], 32'hABCD_EF00);

      // simultaneous write and read
      access(1, 1, 1, 32'h8000_1020, 32'h5A5A_5A5A, 4'hF, 0, rd, er, cyc);
      chk("both_cyc", cyc, 4);
      chk("both_err", 32'(er), 32'd1);
      @(negedge clk);
      chk("both_wr_cnt", wr_cnt_s[1], 32'd2);
      chk("both_rd_cnt", rd_cnt_s[1], 32'd1);
      access(1, 0, 1, 32'h8000_1020, 32'h0, 4'h0, 0, rd, er, cyc);
      chk("both_data", rd, 32'h5A5A_5A5A);

      // reset on the 2nd WAIT cycle of a WRITE_WAIT=4 write
      access(2, 1, 0, 32'h1008, 32'h8765_4321, 4'hF, 0, rd, er, cyc);
      chk("ww4_cyc", cyc, 6);
      @(posedge clk); #1;
      we_s[2] = 1'b1; addr_s[2] = 32'h1008; wdata_s[2] = 32'h0; be_s[2] = 4'hF;
      @(posedge clk);
      @(posedge clk); #2;
      rst_n = 1'b0; we_s[2] = 1'b0;
      @(negedge clk);
      chk("rstw_busy", 32'(busy_s[2]), 32'd0);
      chk("rstw_ready", 32'(ready_s[2]), 32'd1);
      chk("rstw_wr_cnt", wr_cnt_s[2], 32'd0);
      chk("rstw_rd_cnt1", rd_cnt_s[1], 32'd0);
      @(posedge clk);
      @(posedge clk); #3 rst_n = 1'b1;
      access(2, 0, 1, 32'h1008, 32'h0, 4'h0, 0, rd, er, cyc);
      chk("rstw_cyc", cyc, 3);
      chk("rstw_data", rd, 32'h8765_4321);
      @(negedge clk);
      chk("rstw_wr_cnt2", wr_cnt_s[2], 32'd0);
      chk("rstw_rd_cnt2", rd_cnt_s[2], 32'd1);

      // random traffic on all instances concurrently
      for (int i = 0; i < 3; i++)
         for (int k = 0; k < 8; k++)
            access(i, 1, 0, BASE[i] + 32'h1000 + 32'(4 * k), 32'($urandom), 4'hF, 0, rd, er, cyc);
      fork
         rnd_run(0, 80);
         rnd_run(1, 50);
         rnd_run(2, 50);
      join
      repeat (10) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
